// File: rtl/nes_input_pkg.sv
// -----------------------------------------------------------------------------
// nes_input_pkg
// Shared constants and types for the NES controller input path.
//   - Button bit positions in the receiver's 8-bit level vector
//     {right,left,down,up,start,select,B,A}.
//   - Event kind codes and the 5-bit event word layout {kind[1:0], idx[2:0]}.
// -----------------------------------------------------------------------------
package nes_input_pkg;

    localparam int NUM_BTN    = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int EVT_W = 5;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    // Packed so it can be handed to the FIFO as a plain EVT_W-bit vector.
    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] idx;
    } evt_t;

endpackage

// File: rtl/nes_event_fifo.sv
// -----------------------------------------------------------------------------
// nes_event_fifo
// Small synchronous FIFO holding button event words.
//   clk, reset   : clock and synchronous active-high reset (empties the queue)
//   push         : write push_data this cycle (ignored when full unless a pop
//                  happens in the same cycle)
//   push_data    : entry to enqueue
//   pop          : consume the head entry (ignored when empty)
//   full, empty  : occupancy flags
//   head_data    : current head entry; reads as zero while empty
// DEPTH must be a power of two >= 2. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
// Writes land in the array and are only visible through the head the
// following cycle, so an empty FIFO never bypasses push_data to the output.
// -----------------------------------------------------------------------------
module nes_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO may accept.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset; the empty gate below hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/nes_button_events.sv
// -----------------------------------------------------------------------------
// nes_button_events
// Turns the NES receiver's eight button levels into a queue of press /
// release (and optionally auto-repeat) events for the game logic.
//   clk          : system clock
//   reset        : synchronous active-high reset; drops all queued/pending events
//   btn_raw      : {right,left,down,up,start,select,B,A}, 1 = pressed
//   btn_state    : debounced levels, same bit order
//   evt_valid    : event queue non-empty
//   evt_data     : head event {kind[1:0], idx[2:0]}; 01 press, 10 release,
//                  11 repeat
//   evt_ready    : consumer takes evt_data this cycle
//   evt_overflow : sticky flag, an event was lost; cleared only by reset
// Optional build macro NES_AUTOREPEAT_EN adds a d-pad auto-repeat timer
// (bits 4..7) that produces repeat events; without it kind 11 never appears.
// Pipeline: 2-flop sync -> per-bit debounce -> edge detect -> pending bits
// -> lowest-index arbiter -> event FIFO.
// -----------------------------------------------------------------------------
module nes_button_events
    import nes_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               evt_valid,
    output logic [EVT_W-1:0]   evt_data,
    input  logic               evt_ready,
    output logic               evt_overflow
);

    // Elaboration-time sanity check of the parameter set.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("nes_button_events: invalid parameter set");
    end

    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Input synchroniser
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_reg;
    logic [NUM_BTN-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Per-bit debounce: the synced level must disagree with the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles before it is taken over.
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] state_vec;

    genvar gi;
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
        logic [DB_W-1:0] cnt_reg;
        logic            state_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg   <= '0;
                state_reg <= 1'b0;
            end else if (sync2_reg[gi] != state_reg) begin
                if (cnt_reg == DB_LAST) begin
                    cnt_reg   <= '0;
                    state_reg <= ~state_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end

        assign state_vec[gi] = state_reg;
    end

    assign btn_state = state_vec;

    // -------------------------------------------------------------------------
    // Edge detection on the debounced levels
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] prev_reg;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= state_vec;
        end
    end

    assign rise = state_vec & ~prev_reg;
    assign fall = ~state_vec & prev_reg;

    // -------------------------------------------------------------------------
    // Pending bits, arbiter and FIFO
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] pend_press_reg;
    logic [NUM_BTN-1:0] pend_rel_reg;
    logic [NUM_BTN-1:0] pend_rep;
    logic [NUM_BTN-1:0] pend_any;
    logic [NUM_BTN-1:0] grant_oh;
    logic [NUM_BTN-1:0] take_press;
    logic [NUM_BTN-1:0] take_rel;
    logic [NUM_BTN-1:0] lost;
    logic               overflow_reg;
    logic               grant_valid;
    logic [2:0]         grant_idx;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    evt_t               push_evt;

    assign pend_any = pend_press_reg | pend_rel_reg | pend_rep;

    // Lowest index with anything pending wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend_any[i]) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(i);
            end
        end
    end

    assign evt_valid = !fifo_empty;
    assign fifo_pop  = evt_valid && evt_ready;
    assign push      = grant_valid && (!fifo_full || fifo_pop);
    assign grant_oh  = push ? (NUM_BTN'(1) << grant_idx) : '0;

    // Within one button: press before repeat before release. A press and a
    // release are never pending together; a repeat queued before a release
    // must leave first to keep the events in time order.
    assign take_press = grant_oh & pend_press_reg;
    assign take_rel   = grant_oh & ~pend_press_reg & ~pend_rep & pend_rel_reg;

    always_comb begin
        push_evt.idx = grant_idx;
        if (pend_press_reg[grant_idx]) begin
            push_evt.kind = EVT_PRESS;
        end else if (pend_rep[grant_idx]) begin
            push_evt.kind = EVT_REPEAT;
        end else begin
            push_evt.kind = EVT_RELEASE;
        end
    end

    // An opposite edge overwrites an event that has not reached the FIFO yet;
    // one that is being pushed this very cycle is not lost.
    assign lost = (rise & pend_rel_reg & ~take_rel) |
                  (fall & pend_press_reg & ~take_press);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_press_reg <= '0;
            pend_rel_reg   <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            pend_press_reg <= ((pend_press_reg & ~take_press) | rise) & ~fall;
            pend_rel_reg   <= ((pend_rel_reg & ~take_rel) | fall) & ~rise;
            if (|lost) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign evt_overflow = overflow_reg;

    nes_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (evt_data)
    );

    // -------------------------------------------------------------------------
    // D-pad auto-repeat
    // -------------------------------------------------------------------------
`ifdef NES_AUTOREPEAT_EN
    localparam int              REP_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              RW           = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [RW-1:0]   DELAY_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]   PERIOD_LAST  = RW'(REPEAT_PERIOD - 1);

    logic [NUM_BTN-1:0] pend_rep_reg;
    logic [NUM_BTN-1:0] take_rep;
    logic [3:0]         dpad_rise;
    logic               new_press;
    logic [2:0]         new_idx;
    logic               rep_active_reg;
    logic               rep_first_reg;
    logic [2:0]         rep_idx_reg;
    logic [RW-1:0]      rep_cnt_reg;
    logic               tracked_fall;
    logic               rep_fire;

    assign pend_rep  = pend_rep_reg;
    assign take_rep  = grant_oh & ~pend_press_reg & pend_rep_reg;
    assign dpad_rise = rise[BTN_RIGHT:BTN_UP];
    assign new_press = |dpad_rise;

    // Several d-pad bits rising together: track the highest one.
    always_comb begin
        new_idx = 3'(BTN_UP);
        for (int j = 0; j < 4; j++) begin
            if (dpad_rise[j]) begin
                new_idx = 3'(BTN_UP + j);
            end
        end
    end

    assign tracked_fall = fall[rep_idx_reg];

    // A restart or a release of the tracked bit in the same cycle wins over
    // a timer expiry.
    assign rep_fire = rep_active_reg && !new_press && !tracked_fall &&
                      (rep_first_reg ? (rep_cnt_reg == DELAY_LAST)
                                     : (rep_cnt_reg == PERIOD_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_active_reg <= 1'b0;
            rep_first_reg  <= 1'b0;
            rep_idx_reg    <= '0;
            rep_cnt_reg    <= '0;
        end else if (new_press) begin
            rep_active_reg <= 1'b1;
            rep_first_reg  <= 1'b1;
            rep_idx_reg    <= new_idx;
            rep_cnt_reg    <= '0;
        end else if (rep_active_reg && tracked_fall) begin
            rep_active_reg <= 1'b0;
        end else if (rep_active_reg) begin
            if (rep_fire) begin
                rep_cnt_reg   <= '0;
                rep_first_reg <= 1'b0;
            end else begin
                rep_cnt_reg <= rep_cnt_reg + 1'b1;
            end
        end
    end

    // A repeat hitting an already-pending repeat simply merges.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_rep_reg <= '0;
        end else begin
            pend_rep_reg <= (pend_rep_reg & ~take_rep) |
                            (rep_fire ? (NUM_BTN'(1) << rep_idx_reg) : '0);
        end
    end
`else
    assign pend_rep = '0;
`endif

endmodule
